blob_binarizer: RTL

- Upstream feeder of the blob counter in the DE2-115 camera path.
- Converts the raster RGB camera stream (640x480) into the 1-bit foreground stream that the blob counter consumes on i_valid/i_seq.
- Computes luma, thresholds it, and applies a 3-tap horizontal majority filter to kill single-pixel noise.
- Frame-aligns the stream with SOF/EOF marks and raster coordinates.

---
 rtl/blob_pkg.sv | 21 ++
 rtl/blob_binarizer_luma.sv | 24 ++
 rtl/blob_binarizer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/blob_pkg.sv
// Shared definitions for the blob-counting camera path: frame geometry,
// coordinate widths, binarizer states and the 3-input majority helper.
package blob_pkg;

  localparam int IMG_COL = 640;
  localparam int IMG_ROW = 480;
  localparam int COL_W   = 10;
  localparam int ROW_W   = 9;
  localparam int PIX_W   = 12;

  typedef enum logic [1:0] {
    S_WAIT_SOF = 2'd0,
    S_RUN      = 2'd1,
    S_TAIL     = 2'd2
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/blob_binarizer_luma.sv
// Combinational luma (R + 2G + B) / 4, threshold compare and polarity select.
// Kept separate so a later vertical filter can reuse the same pixel classifier.
module bin_luma_cmp #(
  parameter int PIX_W = blob_pkg::PIX_W
) (
  input  logic [PIX_W-1:0] i_r,
  input  logic [PIX_W-1:0] i_g,
  input  logic [PIX_W-1:0] i_b,
  input  logic [PIX_W-1:0] i_thresh,
  input  logic             i_invert,
  output logic             o_bit
);

  logic [PIX_W+1:0] sum_s;
  logic [PIX_W-1:0] luma_s;

  // Two guard bits hold 4 * max channel value without wrapping.
  always_comb begin
    sum_s  = {2'b00, i_r} + {1'b0, i_g, 1'b0} + {2'b00, i_b};
    luma_s = sum_s[PIX_W+1:2];
    o_bit  = (luma_s >= i_thresh) ^ i_invert;
  end

endmodule

// File: rtl/blob_binarizer.sv
// Raster RGB to filtered 1-bit foreground stream with frame marks and
// coordinates; feeds the blob counter.
module blob_binarizer
  import blob_pkg::state_t, blob_pkg::S_WAIT_SOF, blob_pkg::S_RUN,
         blob_pkg::S_TAIL, blob_pkg::maj3;
#(
  parameter int IMG_COL = blob_pkg::IMG_COL,
  parameter int IMG_ROW = blob_pkg::IMG_ROW,
  parameter int PIX_W   = blob_pkg::PIX_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic                       i_sof,
  input  logic [PIX_W-1:0]           i_r,
  input  logic [PIX_W-1:0]           i_g,
  input  logic [PIX_W-1:0]           i_b,
  input  logic [PIX_W-1:0]           i_thresh,
  input  logic                       i_invert,
  output logic                       o_valid,
  output logic                       o_seq,
  output logic                       o_sof,
  output logic                       o_eof,
  output logic [blob_pkg::COL_W-1:0] o_col,
  output logic [blob_pkg::ROW_W-1:0] o_row,
  output logic                       o_sync_err
);

  localparam int COL_W = blob_pkg::COL_W;
  localparam int ROW_W = blob_pkg::ROW_W;

  state_t           state_r, state_nxt_s;
  logic             tail_cnt_r, tail_nxt_s;
  logic [COL_W-1:0] col_r, acc_col_s;
  logic [ROW_W-1:0] row_r, acc_row_s, pend_row_r;
  logic [1:0]       win_r;
  logic             pend_r;
  logic             bit_s, accept_s, early_sof_s, last_col_s, last_row_s;
  logic             emit_s, filt_s;

  bin_luma_cmp #(.PIX_W(PIX_W)) u_luma (
    .i_r      (i_r),
    .i_g      (i_g),
    .i_b      (i_b),
    .i_thresh (i_thresh),
    .i_invert (i_invert),
    .o_bit    (bit_s)
  );

  // Accept qualification and coordinates of the beat being accepted.
  always_comb begin
    accept_s    = i_valid & ((state_r == S_RUN) | i_sof);
    acc_col_s   = i_sof ? {COL_W{1'b0}} : col_r;
    acc_row_s   = i_sof ? {ROW_W{1'b0}} : row_r;
    early_sof_s = i_valid & i_sof & (state_r == S_RUN) &
                  ((col_r != {COL_W{1'b0}}) | (row_r != {ROW_W{1'b0}}));
    last_col_s  = (acc_col_s == COL_W'(IMG_COL - 1));
    last_row_s  = (acc_row_s == ROW_W'(IMG_ROW - 1));
    emit_s      = accept_s & (acc_col_s != {COL_W{1'b0}});
    // win_r holds b[c-2], b[c-1]; column 0 is forced to background.
    if (acc_col_s == COL_W'(1)) begin
      filt_s = 1'b0;
    end else begin
      filt_s = maj3(win_r[0], win_r[1], bit_s);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_WAIT_SOF: begin
        if (accept_s) state_nxt_s = S_RUN;
        else          state_nxt_s = S_WAIT_SOF;
      end
      S_RUN: begin
        if (accept_s && last_col_s && last_row_s) state_nxt_s = S_TAIL;
        else                                      state_nxt_s = S_RUN;
      end
      S_TAIL: begin
        if (accept_s)        state_nxt_s = S_RUN;
        else if (tail_cnt_r) state_nxt_s = S_WAIT_SOF;
        else                 state_nxt_s = S_TAIL;
      end
      default: state_nxt_s = S_WAIT_SOF;
    endcase
    tail_nxt_s = (state_r == S_TAIL) && (state_nxt_s == S_TAIL);
  end

  // State, raster position, pixel window and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= S_WAIT_SOF;
      tail_cnt_r <= 1'b0;
      col_r      <= {COL_W{1'b0}};
      row_r      <= {ROW_W{1'b0}};
      win_r      <= 2'b00;
      pend_r     <= 1'b0;
      pend_row_r <= {ROW_W{1'b0}};
      o_valid    <= 1'b0;
      o_seq      <= 1'b0;
      o_sof      <= 1'b0;
      o_eof      <= 1'b0;
      o_col      <= {COL_W{1'b0}};
      o_row      <= {ROW_W{1'b0}};
      o_sync_err <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tail_cnt_r <= tail_nxt_s;
      pend_r     <= accept_s & last_col_s;
      pend_row_r <= acc_row_s;
      o_sync_err <= o_sync_err | early_sof_s;
      if (accept_s) begin
        win_r <= {bit_s, win_r[1]};
        if (last_col_s) begin
          col_r <= {COL_W{1'b0}};
          row_r <= last_row_s ? {ROW_W{1'b0}} : acc_row_s + ROW_W'(1);
        end else begin
          col_r <= acc_col_s + COL_W'(1);
          row_r <= acc_row_s;
        end
      end else begin
        win_r <= win_r;
        col_r <= col_r;
        row_r <= row_r;
      end
      // A pending last column never coincides with an emitting accept.
      if (emit_s) begin
        o_valid <= 1'b1;
        o_seq   <= filt_s;
        o_sof   <= (acc_col_s == COL_W'(1)) && (acc_row_s == {ROW_W{1'b0}});
        o_eof   <= 1'b0;
        o_col   <= acc_col_s - COL_W'(1);
        o_row   <= acc_row_s;
      end else if (pend_r) begin
        o_valid <= 1'b1;
        o_seq   <= 1'b0;
        o_sof   <= 1'b0;
        o_eof   <= (pend_row_r == ROW_W'(IMG_ROW - 1));
        o_col   <= COL_W'(IMG_COL - 1);
        o_row   <= pend_row_r;
      end else begin
        o_valid <= 1'b0;
        o_seq   <= 1'b0;
        o_sof   <= 1'b0;
        o_eof   <= 1'b0;
        o_col   <= o_col;
        o_row   <= o_row;
      end
    end
  end

endmodule
